// File: rtl/video_pkg.sv
// Shared encodings, colour constants and the 565->888 widening helper for the pixel domain.
package video_pkg;

  localparam logic [1:0] MODE_STREAM     = 2'd0;
  localparam logic [1:0] MODE_COLOR_BARS = 2'd1;
  localparam logic [1:0] MODE_CHECKER    = 2'd2;
  localparam logic [1:0] MODE_BLACK      = 2'd3;

  localparam logic [0:0] ST_SEEK = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // Replicate the top bits into the low bits so full scale maps to 0xFF.
  function automatic rgb888_t widen565(input logic [4:0] r5, input logic [5:0] g6,
                                       input logic [4:0] b5);
    rgb888_t c;
    c.r = {r5, r5[4:2]};
    c.g = {g6, g6[5:4]};
    c.b = {b5, b5[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// RGB565 pixel stream from the SoC side into the video timing generator.
interface video_timing_gen_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic [4:0] in_r;
  logic [5:0] in_g;
  logic [4:0] in_b;

  modport master (output in_valid, in_sof, in_r, in_g, in_b, input in_ready);
  modport slave  (input in_valid, in_sof, in_r, in_g, in_b, output in_ready);
endinterface

// File: rtl/video_raster_cnt.sv
// Raster h/v position counters with region decode; reusable by any pixel-domain block.
module video_raster_cnt #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             h_active_c_o,
  output logic             active_c_o,
  output logic             hs_c_o,
  output logic             vs_c_o,
  output logic             first_c_o,
  output logic             line_end_c_o
);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             line_end_c, h_active_c;

  assign line_end_c = (h_q == CNT_W'(H_TOTAL - 1));
  assign h_active_c = (h_q < CNT_W'(H_ACTIVE));

  // Next raster position: h wraps at the end of a line, v advances on each wrap.
  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (line_end_c) begin
      h_d = '0;
      v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
    end
  end

  // Position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o          = h_q;
  assign v_o          = v_q;
  assign h_active_c_o = h_active_c;
  assign active_c_o   = h_active_c && (v_q < CNT_W'(V_ACTIVE));
  assign hs_c_o       = (h_q >= CNT_W'(HS_START)) && (h_q < CNT_W'(HS_START + H_SYNC));
  assign vs_c_o       = (v_q >= CNT_W'(VS_START)) && (v_q < CNT_W'(VS_START + V_SYNC));
  assign first_c_o    = (h_q == '0) && (v_q == '0);
  assign line_end_c_o = line_end_c;
endmodule

// File: rtl/video_timing_gen.sv
// Video timing and pixel source: raster timing, test patterns and an RGB565 stream front end.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned CNT_W    = 12
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [1:0]         mode,
  video_timing_gen_if.slave  stream,
  input  logic               underflow_clr,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_start,
  output logic               underflow,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count
);
  localparam int unsigned BAR_W  = H_ACTIVE / 8;
  localparam logic        HS_ACT = 1'(HS_POL);
  localparam logic        VS_ACT = 1'(VS_POL);

  logic [CNT_W-1:0] pos_h, pos_v;
  logic             h_active_c, active_c, hs_c, vs_c, first_c, line_end_c;
  logic [1:0]       mode_q, mode_eff_c;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] bar_px_q, bar_px_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic             ready_c, uf_set_c;
  rgb888_t          stream_pix_c, pix_c, rgb_q;
  logic             hsync_q, vsync_q, blank_q, frame_start_q, underflow_q;

  video_raster_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_raster (
    .clk_i        (clk_pixel),
    .rst_i        (reset),
    .h_o          (pos_h),
    .v_o          (pos_v),
    .h_active_c_o (h_active_c),
    .active_c_o   (active_c),
    .hs_c_o       (hs_c),
    .vs_c_o       (vs_c),
    .first_c_o    (first_c),
    .line_end_c_o (line_end_c)
  );

  // The mode input is honoured only at pixel (0,0), so a whole frame uses one mode.
  assign mode_eff_c = first_c ? mode : mode_q;

  // Latch the frame mode.
  always_ff @(posedge clk_pixel) begin
    if (reset)        mode_q <= MODE_BLACK;
    else if (first_c) mode_q <= mode;
  end

  // Colour-bar position tracked by a sub-counter that follows h across the active span.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (line_end_c) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_active_c) begin
      if (bar_px_q == CNT_W'(BAR_W - 1)) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + CNT_W'(1);
      end
    end
  end

  // Bar sub-counter registers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Stream lock FSM: SEEK flushes stale pixels and waits for SOF at (0,0); RUN consumes active slots.
  always_comb begin
    state_d      = state_q;
    ready_c      = 1'b0;
    uf_set_c     = 1'b0;
    stream_pix_c = '0;
    if (mode_eff_c != MODE_STREAM) begin
      state_d = ST_SEEK;
    end else begin
      case (state_q)
        ST_SEEK: begin
          if (stream.in_valid && !stream.in_sof) begin
            ready_c = 1'b1;
          end else if (stream.in_valid && stream.in_sof && first_c) begin
            ready_c      = 1'b1;
            stream_pix_c = widen565(stream.in_r, stream.in_g, stream.in_b);
            state_d      = ST_RUN;
          end
        end
        ST_RUN: begin
          if (active_c) begin
            // Missing data, or SOF not lined up with (0,0), drops the lock.
            if (!stream.in_valid || (stream.in_sof != first_c)) begin
              uf_set_c = 1'b1;
              state_d  = ST_SEEK;
            end else begin
              ready_c      = 1'b1;
              stream_pix_c = widen565(stream.in_r, stream.in_g, stream.in_b);
            end
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  // Stream FSM state register.
  always_ff @(posedge clk_pixel) begin
    if (reset) state_q <= ST_SEEK;
    else       state_q <= state_d;
  end

  // Pixel source select; everything outside the active area is black.
  always_comb begin
    pix_c = '0;
    case (mode_eff_c)
      MODE_STREAM:     pix_c = stream_pix_c;
      MODE_COLOR_BARS: pix_c = rgb888_t'(BAR_RGB[bar_idx_q]);
      MODE_CHECKER:    pix_c = (pos_h[3] ^ pos_v[3]) ? rgb888_t'(24'hFFFFFF) : rgb888_t'(24'h0);
      default:         pix_c = '0;
    endcase
    if (!active_c) pix_c = '0;
  end

  // Output stage: one clock from raster position to encoder inputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb_q         <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rgb_q         <= pix_c;
      hsync_q       <= hs_c ? HS_ACT : ~HS_ACT;
      vsync_q       <= vs_c ? VS_ACT : ~VS_ACT;
      blank_q       <= ~active_c;
      frame_start_q <= first_c;
      if (uf_set_c)           underflow_q <= 1'b1;
      else if (underflow_clr) underflow_q <= 1'b0;
    end
  end

  assign stream.in_ready = ready_c & ~reset;
  assign red             = rgb_q.r;
  assign green           = rgb_q.g;
  assign blue            = rgb_q.b;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign blank           = blank_q;
  assign frame_start     = frame_start_q;
  assign underflow       = underflow_q;
  assign h_count         = pos_h;
  assign v_count         = pos_v;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster with a behavioural frame model.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int unsigned HA  = 16, HF = 2, HSW = 3, HB = 3;
  localparam int unsigned VA  = 4,  VF = 1, VSW = 1, VB = 1;
  localparam int unsigned HT  = HA + HF + HSW + HB;   // 24
  localparam int unsigned VT  = VA + VF + VSW + VB;   // 7
  localparam int unsigned FT  = HT * VT;              // 168
  localparam int unsigned PPF = HA * VA;              // 64 pixels per frame
  localparam int unsigned CW  = 12;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs, vs, blank, fs, uf;
  } pix_rec_t;

  typedef struct packed {
    logic          ready, first, chk, pos_ok;
    logic [CW-1:0] h, v;
  } rdy_rec_t;

  logic          clk_pixel = 1'b0;
  logic          reset, underflow_clr;
  logic [1:0]    mode;
  logic [7:0]    red, green, blue;
  logic          hsync, vsync, blank, frame_start, underflow;
  logic [CW-1:0] h_count, v_count;

  video_timing_gen_if sif ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .CNT_W(CW)
  ) dut (
    .clk_pixel     (clk_pixel),
    .reset         (reset),
    .mode          (mode),
    .stream        (sif),
    .underflow_clr (underflow_clr),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync         (hsync),
    .vsync         (vsync),
    .blank         (blank),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .h_count       (h_count),
    .v_count       (v_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int          n_checks = 0;
  int          n_fail   = 0;
  pix_rec_t    pq[$];
  rdy_rec_t    rq[$];
  pix_rec_t    pe;
  rdy_rec_t    re;
  int unsigned acc_cnt   = 0;
  logic        acc_armed = 1'b0;

  // Stimulus controls and model state.
  logic        rst_c, clr_c, chk_acc, stall_arm, early_arm;
  logic [1:0]  mode_c, mode_lat;
  int          src_mode;        // 0 idle, 1 continuous, 2 random gaps
  int unsigned t;               // cycles since reset release (position of next cycle)
  logic        locked, uf_m;
  int unsigned src_idx;
  logic [4:0]  sr, sb;
  logic [5:0]  sg;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand565(input logic [4:0] r, input logic [5:0] g,
                                             input logic [4:0] b);
    int unsigned r8, g8, b8;
    r8 = 32'(r) * 8 + 32'(r) / 4;
    g8 = 32'(g) * 4 + 32'(g) / 16;
    b8 = 32'(b) * 8 + 32'(b) / 4;
    return {8'(r8), 8'(g8), 8'(b8)};
  endfunction

  function automatic logic [23:0] bar_colour(input int unsigned idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic next_src_pixel();
    src_idx = (src_idx + 1) % PPF;
    sr = 5'($urandom);
    sg = 6'($urandom);
    sb = 5'($urandom);
  endtask

  // Drive one cycle of inputs and push the expected response for it.
  task automatic apply();
    int unsigned h, v;
    logic        first, active, valid, sof, ready, set_uf, clr;
    logic [1:0]  me;
    logic [23:0] rgb;
    pix_rec_t    p;
    rdy_rec_t    r;
    h   = t % HT;
    v   = (t / HT) % VT;
    clr = clr_c || (src_mode == 2 && $urandom_range(0, 15) == 0);
    if (!rst_c && early_arm && h == 7 && v == 1) begin
      src_idx   = PPF - 1;
      next_src_pixel();     // source restarts a frame here, early
      clr       = 1'b1;     // clear collides with the new error
      early_arm = 1'b0;
    end
    valid = (src_mode == 1) || (src_mode == 2 && $urandom_range(0, 7) != 0);
    if (!rst_c && stall_arm && h == 5 && v == 2) begin
      valid     = 1'b0;
      stall_arm = 1'b0;
    end
    sof = (src_idx == 0);

    reset         = rst_c;
    mode          = mode_c;
    underflow_clr = clr;
    sif.in_valid  = valid;
    sif.in_sof    = sof;
    sif.in_r      = sr;
    sif.in_g      = sg;
    sif.in_b      = sb;

    if (rst_c) begin
      p = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank: 1'b1, fs: 1'b0, uf: 1'b0};
      r = '{ready: 1'b0, first: 1'b0, chk: 1'b0, pos_ok: 1'b0, h: '0, v: '0};
      t = 0; locked = 1'b0; uf_m = 1'b0; mode_lat = MODE_BLACK;
    end else begin
      first  = (h == 0) && (v == 0);
      active = (h < HA) && (v < VA);
      me     = first ? mode_c : mode_lat;
      if (first) mode_lat = mode_c;
      ready  = 1'b0;
      set_uf = 1'b0;
      rgb    = 24'h0;
      case (me)
        MODE_STREAM: begin
          if (!locked) begin
            // Hunting: throw away anything that is not a frame start; take SOF only at (0,0).
            if (valid && !sof) ready = 1'b1;
            else if (valid && sof && first) begin
              ready = 1'b1; locked = 1'b1; rgb = expand565(sr, sg, sb);
            end
          end else if (active) begin
            if (valid && (sof == first)) begin
              ready = 1'b1; rgb = expand565(sr, sg, sb);
            end else begin
              set_uf = 1'b1; locked = 1'b0;
            end
          end
        end
        MODE_COLOR_BARS: begin rgb = bar_colour(h / (HA / 8)); locked = 1'b0; end
        MODE_CHECKER: begin
          rgb = (((h / 8) + (v / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0; locked = 1'b0;
        end
        default: locked = 1'b0;
      endcase
      if (!active) rgb = 24'h0;
      if (set_uf)   uf_m = 1'b1;
      else if (clr) uf_m = 1'b0;
      p = '{rgb: rgb,
            hs: !(h >= HA + HF && h < HA + HF + HSW),
            vs: !(v >= VA + VF && v < VA + VF + VSW),
            blank: !active, fs: first, uf: uf_m};
      r = '{ready: ready, first: first, chk: chk_acc, pos_ok: 1'b1, h: CW'(h), v: CW'(v)};
      if (valid && ready) next_src_pixel();
      t++;
    end
    pq.push_back(p);
    rq.push_back(r);
  endtask

  task automatic step();
    @(negedge clk_pixel);
    apply();
  endtask

  task automatic run_until(input int unsigned th, input int unsigned tv);
    for (int i = 0; i < int'(FT); i++) begin
      if ((t % HT) == th && ((t / HT) % VT) == tv) break;
      step();
    end
  endtask

  // Registered pixel outputs, one cycle after the position that produced them.
  always @(posedge clk_pixel) begin
    #1;
    if (pq.size() > 0) begin
      pe = pq.pop_front();
      chk("rgb", 32'({red, green, blue}), 32'(pe.rgb));
      chk("hsync", 32'(hsync), 32'(pe.hs));
      chk("vsync", 32'(vsync), 32'(pe.vs));
      chk("blank", 32'(blank), 32'(pe.blank));
      chk("frame_start", 32'(frame_start), 32'(pe.fs));
      chk("underflow", 32'(underflow), 32'(pe.uf));
    end
  end

  // Handshake and position checks within the cycle, plus accepted-pixels-per-frame.
  always @(negedge clk_pixel) begin
    #2;
    if (rq.size() > 0) begin
      re = rq.pop_front();
      chk("in_ready", 32'(sif.in_ready), 32'(re.ready));
      if (re.pos_ok) begin
        chk("h_count", 32'(h_count), 32'(re.h));
        chk("v_count", 32'(v_count), 32'(re.v));
      end
      if (re.first) begin
        if (re.chk && acc_armed) chk("accepted_per_frame", 32'(acc_cnt), 32'(PPF));
        acc_cnt   = 0;
        acc_armed = re.chk;
      end
      if (sif.in_valid && sif.in_ready) acc_cnt++;
    end
  end

  initial begin
    reset = 1'b1; mode = MODE_BLACK; underflow_clr = 1'b0;
    sif.in_valid = 1'b0; sif.in_sof = 1'b0; sif.in_r = '0; sif.in_g = '0; sif.in_b = '0;
    rst_c = 1'b1; clr_c = 1'b0; chk_acc = 1'b0; stall_arm = 1'b0; early_arm = 1'b0;
    mode_c = MODE_BLACK; mode_lat = MODE_BLACK; src_mode = 0; t = 0;
    locked = 1'b0; uf_m = 1'b0; src_idx = 0; sr = '0; sg = '0; sb = '0;

    repeat (3) step();
    rst_c = 1'b0;
    repeat (2 * FT) step();                  // BLACK: sync/blank/frame_start timing

    repeat (FT / 2) step();
    mode_c = MODE_COLOR_BARS;                // mid-frame: bars appear from next frame
    run_until(0, 0);
    repeat (FT) step();
    repeat (50) step();
    mode_c = MODE_CHECKER;
    run_until(0, 0);
    repeat (FT) step();

    // Continuous stream, first pixel 1F/20/01.
    repeat (30) step();
    src_mode = 1; src_idx = 0; sr = 5'h1F; sg = 6'h20; sb = 5'h01;
    mode_c = MODE_STREAM;
    chk_acc = 1'b1;
    run_until(0, 0);
    repeat (3 * FT + 1) step();
    chk_acc = 1'b0;

    stall_arm = 1'b1;                        // source gap at (5,2), relock at next SOF
    run_until(0, 0);
    repeat (FT) step();
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    early_arm = 1'b1;                        // early SOF at (7,1) with a colliding clear
    repeat (2 * FT) step();

    src_mode = 2;
    repeat (3 * FT) step();

    // Reset mid-line, then a mid-frame mode change.
    src_mode = 1;
    run_until(9, 2);
    rst_c = 1'b1; mode_c = MODE_COLOR_BARS;
    repeat (2) step();
    rst_c = 1'b0;
    repeat (40) step();
    mode_c = MODE_CHECKER;
    run_until(0, 0);
    repeat (FT) step();

    @(posedge clk_pixel);
    #3;
    chk("pix_queue_drained", 32'(pq.size()), 32'd0);
    chk("rdy_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
